alsu_cmd_sequencer: RTL

Initiator side of the ALSU interface. Accepts packed ALSU commands over a valid/ready stream and buffers them in a small FIFO. Drives one command at a time onto the ALSU input pins, waits a fixed pipeline latency, captures the ALSU out/leds result and returns it on a valid/ready response stream. It sits between test or control logic and the ALSU, serialising traffic and counting invalid-operation results.

---
 rtl/alsu_cmd_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alsu_cmd_sequencer.sv
// ALSU command sequencer: buffers packed commands in a small FIFO, issues one
// at a time to the ALSU pins, waits the ALSU pipeline latency, then captures
// out/leds into a held valid/ready response. Also keeps a saturating count
// of responses that flagged an invalid operation.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a queued command
// WAIT  | command on the ALSU pins, counting down the pipeline latency
// HOLD  | response captured, held until the consumer takes it
module alsu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 3,
  parameter int CNT_W   = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [15:0]                  cmd_data,
  output logic [15:0]                  alsu_cmd,
  input  logic [5:0]                   alsu_out,
  input  logic [15:0]                  alsu_leds,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [5:0]                   rsp_out,
  output logic                         rsp_invalid,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         busy,
  output logic [CNT_W-1:0]             inv_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FCNT_W = $clog2(DEPTH+1);
  localparam int WAIT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY+1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t            state, state_nxt;
  logic [15:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [WAIT_W-1:0] wait_cnt;
  logic              push, pop, capture, fifo_empty, leds_any;

  assign fifo_empty = (fifo_count == '0);
  assign cmd_ready  = (fifo_count != FCNT_W'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign busy       = (state != IDLE);
  assign leds_any   = |alsu_leds;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, pop and capture decisions; a pop only ever reads what was
  // already stored, so a push into an empty FIFO issues on the following edge.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
        2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Issue register, latency down-counter, response capture and invalid count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alsu_cmd    <= '0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_out     <= '0;
      rsp_invalid <= 1'b0;
      inv_count   <= '0;
    end else begin
      if (pop) begin
        alsu_cmd <= mem[rd_ptr];
        wait_cnt <= WAIT_LOAD;
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end
      if (capture) begin
        rsp_valid   <= 1'b1;
        rsp_out     <= alsu_out;
        rsp_invalid <= leds_any;
        if (leds_any && inv_count != '1) inv_count <= inv_count + CNT_W'(1);
      end else if (state == HOLD && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
